// File: rtl/node_packet_sender_if.sv
// Node-to-sender packet port plus the 8-bit free/put/payload router link.
// master = node/router side, slave = node_packet_sender.
interface node_packet_sender_if #(
   parameter int unsigned DEPTH = 4
) ();
   localparam int unsigned OW = $clog2(DEPTH) + 1;

   logic          enq;
   logic [31:0]   pkt_in;
   logic          full;
   logic [OW-1:0] occupancy;
   logic          free_outbound;
   logic          put_outbound;
   logic [7:0]    payload_outbound;

   modport master (
      output enq, pkt_in, free_outbound,
      input  full, occupancy, put_outbound, payload_outbound
   );

   modport slave (
      input  enq, pkt_in, free_outbound,
      output full, occupancy, put_outbound, payload_outbound
   );
endinterface

// File: rtl/node_packet_sender.sv
// Node transmit stage: packet FIFO feeding a 4-byte LSB-first serializer onto the router link.
// Defining NODE_SENDER_STATS_EN adds saturating pkts_sent / pkts_dropped counters.
module node_packet_sender #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_b,
   node_packet_sender_if.slave if_bus
`ifdef NODE_SENDER_STATS_EN
   ,
   output logic [15:0]         o_pkts_sent,
   output logic [15:0]         o_pkts_dropped
`endif
);
   localparam int unsigned   PW       = $clog2(DEPTH);
   localparam int unsigned   OW       = PW + 1;
   localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [OW-1:0] r_occ, w_occ_nxt;
   // Byte0 goes straight to the link on pop, so only bytes 1..3 are held here.
   logic [23:0]   r_shift, w_shift_nxt;
   logic [1:0]    r_cnt, w_cnt_nxt;
   logic          r_put, w_put_nxt;
   logic [7:0]    r_payload, w_payload_nxt;
   logic [31:0]   w_head;
   logic          w_full, w_enq_ok, w_drop, w_pop, w_sent;

   assign w_head   = r_mem[r_rptr];
   assign w_full   = (r_occ == FULL_OCC);
   assign w_enq_ok = if_bus.enq && !w_full;
   assign w_drop   = if_bus.enq && w_full;
   // A rejected enqueue freezes the whole FIFO for that cycle, including the pop.
   assign w_pop    = (r_state == StIdle) && (r_occ != '0) && if_bus.free_outbound && !w_drop;

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_cnt_nxt     = r_cnt;
      w_put_nxt     = r_put;
      w_payload_nxt = r_payload;
      w_sent        = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_pop) begin
               w_shift_nxt   = w_head[31:8];
               w_payload_nxt = w_head[7:0];
               w_put_nxt     = 1'b1;
               w_cnt_nxt     = 2'd0;
               w_state_nxt   = StSend;
            end
         end
         StSend: begin
            if (r_cnt == 2'd3) begin
               w_put_nxt   = 1'b0;
               w_sent      = 1'b1;
               w_state_nxt = StGap;
            end else begin
               w_payload_nxt = r_shift[7:0];
               w_shift_nxt   = r_shift >> 8;
               w_cnt_nxt     = r_cnt + 2'd1;
            end
         end
         StGap:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_occ_nxt = r_occ;
      if (w_enq_ok && !w_pop) begin
         w_occ_nxt = r_occ + OW'(1);
      end else if (!w_enq_ok && w_pop) begin
         w_occ_nxt = r_occ - OW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_b) begin
         r_state   <= StIdle;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_occ     <= '0;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_put     <= 1'b0;
         r_payload <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_occ     <= w_occ_nxt;
         r_shift   <= w_shift_nxt;
         r_cnt     <= w_cnt_nxt;
         r_put     <= w_put_nxt;
         r_payload <= w_payload_nxt;
         if (w_enq_ok) r_wptr <= r_wptr + PW'(1);
         if (w_pop)    r_rptr <= r_rptr + PW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_enq_ok) r_mem[r_wptr] <= if_bus.pkt_in;
   end

   assign if_bus.full             = w_full;
   assign if_bus.occupancy        = r_occ;
   assign if_bus.put_outbound     = r_put;
   assign if_bus.payload_outbound = r_payload;

`ifdef NODE_SENDER_STATS_EN
   logic [15:0] r_pkts_sent, r_pkts_dropped;

   always_ff @(posedge i_clk) begin
      if (!i_rst_b) begin
         r_pkts_sent    <= '0;
         r_pkts_dropped <= '0;
      end else begin
         if (w_sent && r_pkts_sent != 16'hFFFF)    r_pkts_sent    <= r_pkts_sent + 16'd1;
         if (w_drop && r_pkts_dropped != 16'hFFFF) r_pkts_dropped <= r_pkts_dropped + 16'd1;
      end
   end

   assign o_pkts_sent    = r_pkts_sent;
   assign o_pkts_dropped = r_pkts_dropped;
`endif
endmodule
